// File: rtl/magnitude_sqrt_unit.sv
// magnitude_sqrt_unit
// Iterative restoring square root of the saturated sum-of-squares word.
// One root bit is resolved per clock, with the most significant radicand pair
// consumed first. A start/busy/valid handshake lets the upstream valid strobe
// drive start directly. R and Rem change only when a result completes.

module magnitude_sqrt_unit #(
  parameter int Width = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [Width-1:0]     M,
  output logic [Width/2-1:0]   R,
  output logic [Width/2:0]     Rem,
  output logic                 busy,
  output logic                 valid
);

  localparam int Half = Width / 2;
  localparam int CntW = $clog2(Half) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   op_q, op_d;
  logic [Half-1:0]    root_q, root_d;
  logic [Half+1:0]    rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [Half-1:0]    r_q, r_d;
  logic [Half:0]      rem_out_q, rem_out_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  // Iteration datapath signals.
  logic [Half+3:0]    rem_shift_s;
  logic [Half+3:0]    trial_s;
  logic               trial_ge_s;
  logic [Half-1:0]    root_next_s;
  logic [Half+1:0]    rem_next_s;
  logic               last_iter_s;

  // One restoring step: shift in the next radicand pair and try the subtraction.
  // The trial is computed two bits wider than the remainder register. A
  // non-negative trial always fits in Half+2 bits, so both extra top bits being
  // zero is exactly the "trial >= 0" condition.
  always_comb begin
    rem_shift_s = {rem_q, op_q[Width-1 -: 2]};
    trial_s     = rem_shift_s - {2'b00, root_q, 2'b01};
    trial_ge_s  = ~(|trial_s[Half+3:Half+2]);
    if (trial_ge_s) begin
      rem_next_s  = trial_s[Half+1:0];
      root_next_s = {root_q[Half-2:0], 1'b1};
    end else begin
      rem_next_s  = rem_shift_s[Half+1:0];
      root_next_s = {root_q[Half-2:0], 1'b0};
    end
    last_iter_s = (cnt_q == CntW'(Half - 1));
  end

  // Next-state and next-output logic of the IDLE/CALC/DONE controller.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    root_d    = root_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    rem_out_d = rem_out_q;
    busy_d    = 1'b0;
    valid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          op_d    = M;
          root_d  = {Half{1'b0}};
          rem_d   = {(Half+2){1'b0}};
          cnt_d   = {CntW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        op_d   = {op_q[Width-3:0], 2'b00};
        root_d = root_next_s;
        rem_d  = rem_next_s;
        cnt_d  = cnt_q + CntW'(1);
        if (last_iter_s) begin
          state_d   = S_DONE;
          r_d       = root_next_s;
          rem_out_d = rem_next_s[Half:0];
          valid_d   = 1'b1;
          busy_d    = 1'b0;
        end else begin
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          op_d    = M;
          root_d  = {Half{1'b0}};
          rem_d   = {(Half+2){1'b0}};
          cnt_d   = {CntW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      op_q      <= {Width{1'b0}};
      root_q    <= {Half{1'b0}};
      rem_q     <= {(Half+2){1'b0}};
      cnt_q     <= {CntW{1'b0}};
      r_q       <= {Half{1'b0}};
      rem_out_q <= {(Half+1){1'b0}};
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      root_q    <= root_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      rem_out_q <= rem_out_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign R     = r_q;
  assign Rem   = rem_out_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule
